// File: rtl/stc0_wb_stream_bridge.sv
// Wishbone slave bridging CPU words to the stc0_core 8-bit ingress stream and
// capturing stc0_core egress bytes into a CPU-readable RX FIFO.
module stc0_wb_stream_bridge #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  id_data,
  output logic        id_valid,
  input  logic [7:0]  ed_data,
  input  logic        ed_valid
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;
  localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic            ack_reg;
  logic [31:0]     dat_o_reg;
  logic [1:0]      ctrl_reg;
  logic            tx_ovf_reg, rx_ovf_reg;

  logic [31:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0]  tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [TCW-1:0]  tx_count_reg;
  logic [7:0]      rx_mem [RX_DEPTH];
  logic [RAW-1:0]  rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [RCW-1:0]  rx_count_reg;

  state_t          state_reg, state_next;
  logic [1:0]      idx_reg, idx_next;
  logic [31:0]     word_reg, word_next;
  logic            id_valid_reg, id_valid_next;
  logic [7:0]      id_data_reg, id_data_next;

  logic            req, hit;
  logic [1:0]      reg_sel;
  logic            wr_txdata, rd_rxdata, wr_status, wr_ctrl;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic            tx_push, tx_pop, rx_push, rx_pop;
  logic            tx_en, msb_first;
  logic [31:0]     tx_head;
  logic [7:0]      rx_head;
  logic [31:0]     status_word, rd_data;
  logic            unused_adr_bits;

  assign unused_adr_bits = ^wbs_adr_i[1:0];

  // Byte k of the word in transmission order.
  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] k,
                                      input logic msb);
    logic [1:0] s;
    s = msb ? ~k : k;
    return w[{s, 3'b000} +: 8];
  endfunction

  assign hit       = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  assign req       = wbs_cyc_i & wbs_stb_i & ~ack_reg & hit;
  assign reg_sel   = wbs_adr_i[3:2];
  assign wr_txdata = req &  wbs_we_i & (reg_sel == 2'd0);
  assign rd_rxdata = req & ~wbs_we_i & (reg_sel == 2'd1);
  assign wr_status = req &  wbs_we_i & (reg_sel == 2'd2);
  assign wr_ctrl   = req &  wbs_we_i & (reg_sel == 2'd3);

  assign tx_en     = ctrl_reg[0];
  assign msb_first = ctrl_reg[1];
  assign tx_full   = (tx_count_reg == TX_FULL_CNT);
  assign tx_empty  = (tx_count_reg == '0);
  assign rx_full   = (rx_count_reg == RX_FULL_CNT);
  assign rx_empty  = (rx_count_reg == '0);
  assign tx_head   = tx_mem[tx_rd_ptr_reg];
  assign rx_head   = rx_mem[rx_rd_ptr_reg];

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign tx_push = wr_txdata & (wbs_sel_i == 4'hF) & (~tx_full | tx_pop);
  assign rx_pop  = rd_rxdata & ~rx_empty;
  assign rx_push = ed_valid & (~rx_full | rx_pop);

  assign status_word = {11'b0, (state_reg == SEND), rx_ovf_reg, tx_ovf_reg,
                        rx_empty, tx_full, 8'(rx_count_reg), 8'(tx_count_reg)};

  always_comb begin
    rd_data = 32'b0;
    case (reg_sel)
      2'd1:    rd_data = rx_empty ? 32'b0 : {1'b1, 23'b0, rx_head};
      2'd2:    rd_data = status_word;
      2'd3:    rd_data = {30'b0, ctrl_reg};
      default: rd_data = 32'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= wbs_dat_i;
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= ed_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg       <= 1'b0;
      dat_o_reg     <= 32'b0;
      ctrl_reg      <= 2'b0;
      tx_ovf_reg    <= 1'b0;
      rx_ovf_reg    <= 1'b0;
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
    end else begin
      ack_reg <= req;
      if (req) dat_o_reg <= wbs_we_i ? 32'b0 : rd_data;
      if (wr_ctrl && wbs_sel_i[0]) ctrl_reg <= wbs_dat_i[1:0];

      // Setting an overflow wins over a same-cycle W1C so no event is lost.
      tx_ovf_reg <= (wr_txdata & (wbs_sel_i == 4'hF) & tx_full & ~tx_pop) |
                    (tx_ovf_reg & ~(wr_status & wbs_dat_i[18]));
      rx_ovf_reg <= (ed_valid & rx_full & ~rx_pop) |
                    (rx_ovf_reg & ~(wr_status & wbs_dat_i[19]));

      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + TAW'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + TAW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count_reg <= tx_count_reg + TCW'(1);
        2'b01:   tx_count_reg <= tx_count_reg - TCW'(1);
        default: tx_count_reg <= tx_count_reg;
      endcase

      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + RAW'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + RAW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count_reg <= rx_count_reg + RCW'(1);
        2'b01:   rx_count_reg <= rx_count_reg - RCW'(1);
        default: rx_count_reg <= rx_count_reg;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= IDLE;
      idx_reg      <= 2'd0;
      word_reg     <= 32'b0;
      id_valid_reg <= 1'b0;
      id_data_reg  <= 8'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      word_reg     <= word_next;
      id_valid_reg <= id_valid_next;
      id_data_reg  <= id_data_next;
    end
  end

  // The popped word's first byte is emitted on the same edge as the pop.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    word_next     = word_reg;
    id_valid_next = 1'b0;
    id_data_next  = id_data_reg;
    tx_pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tx_en && !tx_empty) begin
          tx_pop        = 1'b1;
          state_next    = SEND;
          idx_next      = 2'd0;
          word_next     = tx_head;
          id_valid_next = 1'b1;
          id_data_next  = pick(tx_head, 2'd0, msb_first);
        end
      end
      SEND: begin
        if (idx_reg != 2'd3) begin
          idx_next      = idx_reg + 2'd1;
          id_valid_next = 1'b1;
          id_data_next  = pick(word_reg, idx_reg + 2'd1, msb_first);
        end else if (tx_en && !tx_empty) begin
          tx_pop        = 1'b1;
          idx_next      = 2'd0;
          word_next     = tx_head;
          id_valid_next = 1'b1;
          id_data_next  = pick(tx_head, 2'd0, msb_first);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_o_reg;
  assign id_valid  = id_valid_reg;
  assign id_data   = id_data_reg;

endmodule

// File: tb/tb_stc0_wb_stream_bridge.sv
// Scoreboard bench for stc0_wb_stream_bridge: ingress bytes and RXDATA reads
// are compared against queues filled when the stimulus is driven.
module tb_stc0_wb_stream_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  id_data;
  logic        id_valid;
  logic [7:0]  ed_data;
  logic        ed_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int e0_cyc  = 0;
  bit model_msb = 1'b0;

  logic [7:0] id_q[$];
  logic [7:0] rx_q[$];
  int         vstamp[$];
  logic [7:0] id_exp;

  stc0_wb_stream_bridge dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .id_data  (id_data),
    .id_valid (id_valid),
    .ed_data  (ed_data),
    .ed_valid (ed_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Ingress monitor: every valid byte must be the next one the scoreboard expects.
  always @(negedge clk) begin
    if (id_valid === 1'b1) begin
      vstamp.push_back(cyc_cnt);
      if (id_q.size() == 0) begin
        check("id_unexpected_valid", 32'(id_valid), 32'd0);
      end else begin
        id_exp = id_q.pop_front();
        check("id_byte", {24'b0, id_data}, {24'b0, id_exp});
      end
    end
  end

  task automatic wb_cycle(input logic [3:0] off, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
    bit seen = 1'b0;
    @(negedge clk);
    adr = BASE | {28'b0, off}; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    e0_cyc = cyc_cnt;
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!seen) check("ack_timeout", 32'(ack), 32'd1);
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] r;
    wb_cycle(off, 1'b1, d, 4'hF, r);
  endtask

  task automatic wb_read(input logic [3:0] off, output logic [31:0] r);
    wb_cycle(off, 1'b0, 32'b0, 4'hF, r);
  endtask

  task automatic tx_word(input logic [31:0] d, input bit accept);
    wb_write(4'h0, d);
    if (accept)
      for (int k = 0; k < 4; k++)
        id_q.push_back(model_msb ? d[31-8*k -: 8] : d[8*k +: 8]);
  endtask

  task automatic rx_drive(input logic [7:0] b, input bit accept);
    @(negedge clk);
    ed_valid = 1'b1; ed_data = b;
    if (accept) rx_q.push_back(b);
    @(negedge clk);
    ed_valid = 1'b0;
  endtask

  task automatic rx_read_check(input string tag);
    logic [31:0] r;
    logic [7:0]  b;
    wb_read(4'h4, r);
    if (rx_q.size() == 0) begin
      check(tag, r, 32'h0);
    end else begin
      b = rx_q.pop_front();
      check(tag, r, {1'b1, 23'b0, b});
    end
  endtask

  initial begin
    logic [31:0] r;
    bit          found;
    bit          any_ack;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; wdat = 32'h0; ed_data = 8'h0; ed_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat_o", rdat, 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_data", {24'b0, id_data}, 32'd0);
    rst = 1'b0;
    wb_read(4'h8, r); check("rst_status", r, 32'h0002_0000);
    wb_read(4'hC, r); check("rst_ctrl", r, 32'h0);

    // Undecoded address must never be acknowledged.
    any_ack = 1'b0;
    @(negedge clk);
    adr = 32'h4000_0008; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
    repeat (6) begin
      @(negedge clk);
      any_ack = any_ack | ack;
    end
    cyc = 1'b0; stb = 1'b0;
    check("undecoded_ack", 32'(any_ack), 32'd0);

    // Test 1: LSB-first single word, latency and back-to-back byte timing.
    model_msb = 1'b0;
    wb_write(4'hC, 32'h1);
    vstamp.delete();
    tx_word(32'hA1B2_C3D4, 1'b1);
    @(negedge clk);
    check("ack_one_cycle", 32'(ack), 32'd0);
    repeat (8) @(negedge clk);
    check("t1_nbytes", vstamp.size(), 32'd4);
    if (vstamp.size() == 4) begin
      check("t1_first_latency", vstamp[0], e0_cyc + 1);
      check("t1_contiguous", vstamp[3] - vstamp[0], 32'd3);
    end
    wb_read(4'h8, r); check("t1_status_idle", r, 32'h0002_0000);

    // Test 2: MSB-first, two words stream without a gap.
    model_msb = 1'b1;
    wb_write(4'hC, 32'h3);
    vstamp.delete();
    tx_word(32'h0102_0304, 1'b1);
    tx_word(32'h0506_0708, 1'b1);
    repeat (14) @(negedge clk);
    check("t2_nbytes", vstamp.size(), 32'd8);
    if (vstamp.size() == 8) check("t2_contiguous", vstamp[7] - vstamp[0], 32'd7);

    // Test 3: fill TX with tx_en=0, overflow, W1C, then drain through the scoreboard.
    model_msb = 1'b0;
    wb_write(4'hC, 32'h0);
    for (int i = 0; i < 9; i++) tx_word(32'hC0DE_0000 + 32'(i * 32'h0101), i < 8);
    wb_read(4'h8, r); check("t3_status_full_ovf", r, 32'h0007_0008);
    wb_write(4'h8, 32'h0004_0000);
    wb_read(4'h8, r); check("t3_status_w1c", r, 32'h0003_0008);
    wb_write(4'hC, 32'h1);
    repeat (40) @(negedge clk);
    check("t3_drained_q", id_q.size(), 32'd0);
    wb_read(4'h8, r); check("t3_status_drained", r, 32'h0002_0000);

    // Test 4: RX overflow and drain.
    for (int i = 0; i <= 16; i++) rx_drive(8'(i), i < 16);
    wb_read(4'h8, r); check("t4_status_rx_full_ovf", r, 32'h0008_1000);
    for (int i = 0; i < 17; i++) rx_read_check("t4_rxdata");
    wb_write(4'h8, 32'h0008_0000);
    wb_read(4'h8, r); check("t4_status_w1c", r, 32'h0002_0000);

    // Test 5: full RX FIFO, RXDATA pop and ed_valid push on the same edge.
    for (int i = 0; i < 16; i++) rx_drive(8'(8'h20 + i), 1'b1);
    @(negedge clk);
    adr = BASE | 32'h4; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    ed_valid = 1'b1; ed_data = 8'h30;
    @(negedge clk);
    ed_valid = 1'b0;
    check("t5_ack", 32'(ack), 32'd1);
    r = rdat;
    cyc = 1'b0; stb = 1'b0;
    id_exp = rx_q.pop_front();
    check("t5_simul_read", r, {1'b1, 23'b0, id_exp});
    rx_q.push_back(8'h30);
    wb_read(4'h8, r); check("t5_status", r, 32'h0000_1000);
    for (int i = 0; i < 16; i++) rx_read_check("t5_rxdata");

    // Test 6: reset while the second byte of a word is on the bus.
    model_msb = 1'b0;
    wb_write(4'hC, 32'h0);
    tx_word(32'h1122_3344, 1'b0);
    tx_word(32'h5566_7788, 1'b0);
    id_q.push_back(8'h44);
    id_q.push_back(8'h33);
    wb_write(4'hC, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id_valid === 1'b1 && id_data == 8'h33) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reached_idx1", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_id_valid_after_rst", 32'(id_valid), 32'd0);
    check("t6_ack_after_rst", 32'(ack), 32'd0);
    wb_read(4'h8, r); check("t6_status_after_rst", r, 32'h0002_0000);
    wb_write(4'hC, 32'h1);
    repeat (12) @(negedge clk);
    check("t6_q_empty", id_q.size(), 32'd0);
    check("t6_id_valid_idle", 32'(id_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
